counter_hold_bank: RTL
======================

# counter_hold_bank

Parametrised bank of independent up-counters, each with a combinational scaled view, a hold view that tracks the last even count, and a sticky overflow flag. It generalises the single counter / derived-wire / hold-latch structure to N channels, configurable width, step and scale, with wrap or saturate mode, clear, and a registered snapshot read port. It sits beside the formal regression designs as the reference multi-channel counter for wire, flop and hold inference checks.

## Interface
- WIDTH, 32, counter width per channel (≥2)
- CHANNELS, 4, number of channels (1..16)
- STEP, 1, increment per enabled cycle (1 ≤ STEP < 2^WIDTH)
- SCALE_SHIFT, 1, left shift applied to the scaled view (0..WIDTH-1)
- SEL_W, 4, width of rd_sel (≥ clog2(CHANNELS), ≥1)

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- en  in  CHANNELS  per-channel count enable
- clr  in  CHANNELS  per-channel synchronous clear
- sat_mode  in  1  0 = wrap, 1 = saturate (global)
- cnt_flat  out  CHANNELS*WIDTH  registered counter values, channel i at [i*WIDTH +: WIDTH]
- scaled_flat  out  CHANNELS*WIDTH  combinational (cnt << SCALE_SHIFT) truncated to WIDTH
- hold_flat  out  CHANNELS*WIDTH  combinational hold view
- ovf  out  CHANNELS  sticky overflow/saturation flag
- rd_req  in  1  snapshot request
- rd_sel  in  SEL_W  channel to snapshot
- rd_ack  out  1  snapshot valid, one-cycle pulse
- rd_data  out  WIDTH  snapshot of hold view

## Operation
- Per channel i, priority clr > en > idle:
  - clr[i]=1: cnt←0, ovf[i]←0, last_even←0.
  - en[i]=1, wrap: cnt←(cnt+STEP) mod 2^WIDTH; ovf[i]←1 if the true sum ≥ 2^WIDTH.
  - en[i]=1, saturate: cnt←min(cnt+STEP, 2^WIDTH-1); ovf[i]←1 if clamping occurred (sum > 2^WIDTH-1). Once at max, further enables keep max and ovf set.
  - idle: cnt, ovf unchanged.
- Sum computed at WIDTH+1 bits; no other widening.
- last_even register: each posedge (not clr), if cnt[0]==0 then last_even←cnt, else unchanged.
- hold view = cnt when cnt[0]==0, else last_even. Hold is always even.
- scaled view: pure function of cnt; LSB SCALE_SHIFT bits always 0.
- sat_mode may change any cycle; takes effect on the next increment.
- Snapshot: rd_req=1 at edge k → at edge k+1 rd_ack=1, rd_data = hold view of channel rd_sel as sampled at edge k. rd_sel ≥ CHANNELS → rd_data=0, rd_ack still 1. Back-to-back requests allowed, one ack per request. rd_ack=0 and rd_data holds last value when no request.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, last_even=0, ovf=0, rd_ack=0, rd_data=0; hence scaled=0, hold=0 immediately.
- Reset deassertion mid-operation: first count on first posedge with rst_n high and en set.
- cnt, ovf: latency 1 cycle from en/clr.
- scaled, hold: zero-cycle combinational from registered state; no combinational path from inputs.
- rd_data/rd_ack: latency 1 cycle from rd_req.
- Simultaneous clr and rd_req on same channel: snapshot returns pre-clear hold value.

## Configuration
- COUNTER_HOLD_ASSERT_EN defined: compile in formal properties per channel: scaled LSBs zero (SCALE_SHIFT>0), hold[0]==0, ovf clear after clr, saturate mode never decreases cnt without clr. All must pass.
- Undefined: no assertions; RTL behaviour identical.

## Test plan
- Reset then WIDTH=4, STEP=1, en[0]=1 for 5 cycles → cnt 1,2,3,4,5; hold 0,2,2,4,4; scaled (SCALE_SHIFT=1) 2,4,6,8,10.
- WIDTH=4, wrap, cnt=14, STEP=3, one enable → cnt=1, ovf[0]=1, hold stays 14 until next even.
- WIDTH=4, saturate, cnt=14, STEP=3, three enables → cnt=15,15,15; ovf=1; hold=14.
- cnt=9, ovf=1, clr[0]=1 with en[0]=1 → next cycle cnt=0, ovf=0, hold=0.
- Channel 2 hold=6, rd_req with rd_sel=2, then rd_sel=7 (CHANNELS=4) next cycle → rd_ack two consecutive cycles, rd_data 6 then 0.
- Assert rst_n low mid-count (cnt=7) between edges → all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/counter_hold_bank.sv
// Bank of independent up-counters with scaled view, even-hold view, sticky overflow and snapshot port.
// Define COUNTER_HOLD_ASSERT_EN to compile in per-channel properties.
module counter_hold_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned SEL_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic                      sat_mode,
  output logic [CHANNELS*WIDTH-1:0] cnt_flat,
  output logic [CHANNELS*WIDTH-1:0] scaled_flat,
  output logic [CHANNELS*WIDTH-1:0] hold_flat,
  output logic [CHANNELS-1:0]       ovf,
  input  logic                      rd_req,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic                      rd_ack,
  output logic [WIDTH-1:0]          rd_data
);

  localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] hold [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] even_q, even_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    always_comb begin
      sum    = {1'b0, cnt_q} + StepExt;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      even_d = cnt_q[0] ? even_q : cnt_q;
      if (clr[g]) begin
        cnt_d  = '0;
        ovf_d  = 1'b0;
        even_d = '0;
      end else if (en[g]) begin
        // Carry out of the WIDTH+1 bit sum marks both wrap and clamp.
        if (sum[WIDTH]) begin
          ovf_d = 1'b1;
          cnt_d = sat_mode ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
          cnt_d = sum[WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        even_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        even_q <= even_d;
        ovf_q  <= ovf_d;
      end
    end

    assign hold[g]                          = cnt_q[0] ? even_q : cnt_q;
    assign cnt_flat[g*WIDTH +: WIDTH]    = cnt_q;
    assign scaled_flat[g*WIDTH +: WIDTH] = cnt_q << SCALE_SHIFT;
    assign hold_flat[g*WIDTH +: WIDTH]   = hold[g];
    assign ovf[g]                           = ovf_q;

`ifdef COUNTER_HOLD_ASSERT_EN
    if (SCALE_SHIFT > 0) begin : g_scale_chk
      a_scaled_lsb: assert property (@(posedge clk) disable iff (!rst_n)
        scaled_flat[g*WIDTH +: SCALE_SHIFT] == '0);
    end
    a_hold_even: assert property (@(posedge clk) disable iff (!rst_n) hold[g][0] == 1'b0);
    a_clr_ovf: assert property (@(posedge clk) disable iff (!rst_n) clr[g] |=> !ovf_q);
    a_sat_mono: assert property (@(posedge clk) disable iff (!rst_n)
      (sat_mode && !clr[g]) |=> (cnt_q >= $past(cnt_q)));
`endif
  end

  logic [WIDTH-1:0] rd_hold;
  logic             rd_ack_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_hold = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_hold = hold[i];
    end
    rd_data_d = rd_req ? rd_hold : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_req;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;

endmodule
